// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised 2R/1W register file with per-register pending scoreboard
// Optional same-cycle write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITEENABLE,
  input  logic [ADDR_WIDTH-1:0] WRITEREG,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  input  logic [ADDR_WIDTH-1:0] READREG1,
  input  logic [ADDR_WIDTH-1:0] READREG2,
  output logic [DATA_WIDTH-1:0] REGOUT1,
  output logic [DATA_WIDTH-1:0] REGOUT2,
  input  logic                  RESERVE,
  input  logic [ADDR_WIDTH-1:0] RESERVEREG,
  output logic                  BUSY1,
  output logic                  BUSY2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;

  // Reserve is applied after the write clear so a same-index reserve wins:
  // it belongs to a newer producer than the result being written back.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VALUE;
      end
      pending <= '0;
    end else begin
      if (WRITEENABLE) begin
        regs[WRITEREG]    <= WRITEDATA;
        pending[WRITEREG] <= 1'b0;
      end
      if (RESERVE) begin
        pending[RESERVEREG] <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  always_comb begin
    fwd1    = RESET && WRITEENABLE && (WRITEREG == READREG1);
    fwd2    = RESET && WRITEENABLE && (WRITEREG == READREG2);
    REGOUT1 = fwd1 ? WRITEDATA : regs[READREG1];
    REGOUT2 = fwd2 ? WRITEDATA : regs[READREG2];
    BUSY1   = fwd1 ? 1'b0 : pending[READREG1];
    BUSY2   = fwd2 ? 1'b0 : pending[READREG2];
  end
`else
  always_comb begin
    REGOUT1 = regs[READREG1];
    REGOUT2 = regs[READREG2];
    BUSY1   = pending[READREG1];
    BUSY2   = pending[READREG2];
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb (default and 16x16 instances)
// Expected values follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_reg_file_sb;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst, we, rsv;
  logic [2:0] wreg, rr1, rr2, rsvreg;
  logic [7:0] wdata, out1, out2;
  logic       busy1, busy2;

  // DATA_WIDTH=16, ADDR_WIDTH=4, RESET_VALUE=0xFFFF instance
  logic        p_rst, p_we, p_rsv;
  logic [3:0]  p_wreg, p_rr1, p_rr2, p_rsvreg;
  logic [15:0] p_wdata, p_out1, p_out2;
  logic        p_busy1, p_busy2;

  reg_file_sb dut (
    .CLK(clk), .RESET(rst), .WRITEENABLE(we), .WRITEREG(wreg), .WRITEDATA(wdata),
    .READREG1(rr1), .READREG2(rr2), .REGOUT1(out1), .REGOUT2(out2),
    .RESERVE(rsv), .RESERVEREG(rsvreg), .BUSY1(busy1), .BUSY2(busy2)
  );

  reg_file_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RESET_VALUE(16'hFFFF)) pdut (
    .CLK(clk), .RESET(p_rst), .WRITEENABLE(p_we), .WRITEREG(p_wreg), .WRITEDATA(p_wdata),
    .READREG1(p_rr1), .READREG2(p_rr2), .REGOUT1(p_out1), .REGOUT2(p_out2),
    .RESERVE(p_rsv), .RESERVEREG(p_rsvreg), .BUSY1(p_busy1), .BUSY2(p_busy2)
  );

  typedef struct {
    string       name;
    bit          inst;
    logic [15:0] o1;
    logic [15:0] o2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input bit inst, input logic [15:0] o1, input logic [15:0] o2,
                            input logic b1, input logic b2);
    exp_t e;
    e.name = nm; e.inst = inst; e.o1 = o1; e.o2 = o2; e.b1 = b1; e.b2 = b2;
    sbq.push_back(e);
  endtask

  // monitor: compare all pending expectations away from the active edge
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      if (!e.inst) begin
        cmp(e.name, "regout1", {8'h00, out1}, e.o1);
        cmp(e.name, "regout2", {8'h00, out2}, e.o2);
        cmp(e.name, "busy1", {15'h0, busy1}, {15'h0, e.b1});
        cmp(e.name, "busy2", {15'h0, busy2}, {15'h0, e.b2});
      end else begin
        cmp(e.name, "regout1", p_out1, e.o1);
        cmp(e.name, "regout2", p_out2, e.o2);
        cmp(e.name, "busy1", {15'h0, p_busy1}, {15'h0, e.b1});
        cmp(e.name, "busy2", {15'h0, p_busy2}, {15'h0, e.b2});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; rsv = 1'b0; wreg = '0; rr1 = '0; rr2 = '0; rsvreg = '0; wdata = '0;
    p_rst = 1'b0; p_we = 1'b0; p_rsv = 1'b0; p_wreg = '0; p_rr1 = '0; p_rr2 = '0; p_rsvreg = '0; p_wdata = '0;
    tick; tick;
    rst = 1'b1; p_rst = 1'b1;
    expect_out("reset_state", 0, 16'h00, 16'h00, 1'b0, 1'b0);
    expect_out("p_reset_state", 1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    // write r5, pend r6, then reset with a write in flight
    we = 1; wreg = 5; wdata = 8'hAA; rsv = 1; rsvreg = 6;
    tick;
    we = 0; rsv = 0; rr1 = 5; rr2 = 6;
    expect_out("pre_reset", 0, 16'hAA, 16'h00, 1'b0, 1'b1);
    tick;
    rst = 0; we = 1; wreg = 5; wdata = 8'h66;
    expect_out("bypass_in_reset", 0, 16'hAA, 16'h00, 1'b0, 1'b1);
    tick;
    rst = 1; we = 0; rr1 = 5; rr2 = 0;
    expect_out("reset", 0, 16'h00, 16'h00, 1'b0, 1'b0);
    tick;

    // write and read on consecutive edges
    rr1 = 0; rr2 = 1; we = 1; wreg = 0; wdata = 8'h33;
    expect_out("write_pre_edge", 0, BYP ? 16'h33 : 16'h00, 16'h00, 1'b0, 1'b0);
    tick;
    wreg = 1; wdata = 8'h5C;
    tick;
    we = 0;
    expect_out("write_read", 0, 16'h33, 16'h5C, 1'b0, 1'b0);
    tick;

    // reserve then write-back; both ports on the same index
    rsv = 1; rsvreg = 3; rr1 = 3; rr2 = 3;
    tick;
    rsv = 0;
    expect_out("reserved", 0, 16'h00, 16'h00, 1'b1, 1'b1);
    tick;
    we = 1; wreg = 3; wdata = 8'h7E;
    tick;
    we = 0;
    expect_out("writeback", 0, 16'h7E, 16'h7E, 1'b0, 1'b0);

    // simultaneous write and reserve, same index
    rsv = 1; rsvreg = 4;
    tick;
    we = 1; wreg = 4; wdata = 8'h11; rsv = 1; rsvreg = 4;
    tick;
    we = 0; rsv = 0; rr1 = 4; rr2 = 4;
    expect_out("wr_rsv_same", 0, 16'h11, 16'h11, 1'b1, 1'b1);

    // write-enable held across edges
    we = 1; wreg = 7; wdata = 8'h01;
    tick;
    wdata = 8'h02;
    tick;
    we = 0; rr1 = 7; rr2 = 4;
    expect_out("we_hold", 0, 16'h02, 16'h11, 1'b0, 1'b1);

    // bypass with r2 pending
    rsv = 1; rsvreg = 2;
    tick;
    rsv = 0; we = 1; wreg = 2; wdata = 8'h9F; rr1 = 3; rr2 = 2;
    expect_out("bypass", 0, 16'h7E, BYP ? 16'h9F : 16'h00, 1'b0, BYP ? 1'b0 : 1'b1);
    tick;
    we = 0;
    expect_out("bypass_after", 0, 16'h7E, 16'h9F, 1'b0, 1'b0);
    tick;
    we = 1; wreg = 2; wdata = 8'h44; rsv = 1; rsvreg = 2;
    expect_out("bypass_rsv", 0, 16'h7E, BYP ? 16'h44 : 16'h9F, 1'b0, 1'b0);
    tick;
    we = 0; rsv = 0;
    expect_out("bypass_rsv_after", 0, 16'h7E, 16'h44, 1'b0, 1'b1);

    // write and reserve, different indices
    we = 1; wreg = 5; wdata = 8'h55; rsv = 1; rsvreg = 6;
    tick;
    we = 0; rsv = 0; rr1 = 5; rr2 = 6;
    expect_out("wr_rsv_diff", 0, 16'h55, 16'h00, 1'b0, 1'b1);

    // parametrised instance
    p_we = 1; p_wreg = 15; p_wdata = 16'h1234;
    tick;
    p_we = 0; p_rr1 = 14; p_rr2 = 15;
    expect_out("param", 1, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
    tick;

    for (int i = 0; i < 5 && sbq.size() > 0; i++) tick;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
